stream_burst_source: RTL

STREAM_BURST_SOURCE -- requirements
Module: stream_burst_source

---
 rtl/stream_burst_source.sv | 92 +++++++++
 1 files changed

// File: rtl/stream_burst_source.sv
// Burst source: a command (start value, length-1) becomes a run of incrementing beats on a
// valid/ready stream. Define STREAM_BURST_SOURCE_LAST_EN to add the out_last port.
`timescale 1ns/1ps

module stream_burst_source #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_start,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
`ifdef STREAM_BURST_SOURCE_LAST_EN
    ,
    output logic                  out_last
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] data_reg,  data_next;
    logic [LEN_WIDTH-1:0]  count_reg, count_next;
    logic                  done_reg,  done_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    // Outputs decode from state only, so no input reaches an output combinationally.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        cmd_ready  = 1'b1;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = RUN;
                    data_next  = cmd_start;
                    count_next = cmd_len;
                end
            end
            RUN: begin
                cmd_ready = 1'b0;
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    if (count_reg != '0) begin
                        data_next  = data_reg + DATA_WIDTH'(1);
                        count_next = count_reg - LEN_WIDTH'(1);
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_data = data_reg;
    assign done     = done_reg;

`ifdef STREAM_BURST_SOURCE_LAST_EN
    assign out_last = (state_reg == RUN) && (count_reg == '0);
`endif

endmodule
